// File: rtl/edge_detector_bank.sv
// Bank of independent synchronise / debounce / edge-detect channels with a
// per-channel pulse output and a sticky pending/missed handshake.
module edge_detector_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [CHANNELS-1:0]   signal_input,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   event_clear,
    output logic [CHANNELS-1:0]   signal_level,
    output logic [CHANNELS-1:0]   edge_pulse,
    output logic [CHANNELS-1:0]   edge_pending,
    output logic [CHANNELS-1:0]   edge_missed,
    output logic                  any_pending
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_chain_r;
        logic [CNT_WIDTH-1:0]   cnt_r;
        logic                   level_r;
        logic                   pulse_r;
        logic                   pending_r;
        logic                   missed_r;
        logic                   sync_out_s;
        logic                   accept_s;
        logic                   mode_hit_s;

        // Level-change acceptance and mode qualification of the pending transition.
        always_comb begin
            sync_out_s = sync_chain_r[SYNC_STAGES-1];
            accept_s   = (sync_out_s != level_r) && (cnt_r == CNT_LAST);
            case (mode[2*i +: 2])
                2'b01:   mode_hit_s = sync_out_s;
                2'b10:   mode_hit_s = ~sync_out_s;
                2'b11:   mode_hit_s = 1'b1;
                default: mode_hit_s = 1'b0;
            endcase
        end

        // Synchroniser, debounce counter, pulse and pending/missed state.
        always_ff @(posedge clk) begin
            if (sync_reset) begin
                sync_chain_r <= {SYNC_STAGES{1'b0}};
                cnt_r        <= CNT_ZERO;
                level_r      <= 1'b0;
                pulse_r      <= 1'b0;
                pending_r    <= 1'b0;
                missed_r     <= 1'b0;
            end else begin
                sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], signal_input[i]};

                if (sync_out_s == level_r) begin
                    cnt_r <= CNT_ZERO;
                end else if (accept_s) begin
                    level_r <= sync_out_s;
                    cnt_r   <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end

                pulse_r <= accept_s & mode_hit_s;

                // A clear coinciding with a new pulse consumes the old event only.
                case ({pulse_r, event_clear[i]})
                    2'b10: begin
                        missed_r  <= missed_r | pending_r;
                        pending_r <= 1'b1;
                    end
                    2'b11: begin
                        pending_r <= 1'b1;
                        missed_r  <= 1'b0;
                    end
                    2'b01: begin
                        pending_r <= 1'b0;
                        missed_r  <= 1'b0;
                    end
                    default: begin
                        pending_r <= pending_r;
                        missed_r  <= missed_r;
                    end
                endcase
            end
        end

        assign signal_level[i] = level_r;
        assign edge_pulse[i]   = pulse_r;
        assign edge_pending[i] = pending_r;
        assign edge_missed[i]  = missed_r;
    end

    assign any_pending = |edge_pending;

endmodule

// File: tb/tb_edge_detector_bank.sv
// Directed bench for edge_detector_bank with 4 channels, 2 sync stages and a
// debounce length of 4, so an accepted edge lands 6 clocks after the input moves.
module tb_edge_detector_bank;

    logic       clk;
    logic       sync_reset;
    logic [3:0] signal_input;
    logic [7:0] mode;
    logic [3:0] event_clear;
    logic [3:0] signal_level;
    logic [3:0] edge_pulse;
    logic [3:0] edge_pending;
    logic [3:0] edge_missed;
    logic       any_pending;

    int passed;
    int total;

    edge_detector_bank #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (4)
    ) dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .signal_input (signal_input),
        .mode         (mode),
        .event_clear  (event_clear),
        .signal_level (signal_level),
        .edge_pulse   (edge_pulse),
        .edge_pending (edge_pending),
        .edge_missed  (edge_missed),
        .any_pending  (any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sig;
        logic [3:0] lvl;
        logic [3:0] pulse;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Move one channel's input and record pulse/level over the following 7 edges.
    task automatic wait_edge(input int ch, input logic val, input logic exp_pulse, input string name);
        logic [6:0] ph;
        logic [6:0] lh;
        signal_input[ch] = val;
        for (int k = 0; k < 7; k++) begin
            tick();
            ph[k] = edge_pulse[ch];
            lh[k] = signal_level[ch];
        end
        check($sformatf("%s_pulse_hist", name), 32'(ph), exp_pulse ? 32'h20 : 32'h0);
        check($sformatf("%s_level_hist", name), 32'(lh), val ? 32'h60 : 32'h1f);
    endtask

    task automatic check_all_zero(input string name);
        check($sformatf("%s_level", name),   32'(signal_level), 32'h0);
        check($sformatf("%s_pulse", name),   32'(edge_pulse),   32'h0);
        check($sformatf("%s_pending", name), 32'(edge_pending), 32'h0);
        check($sformatf("%s_missed", name),  32'(edge_missed),  32'h0);
        check($sformatf("%s_any", name),     32'(any_pending),  32'h0);
    endtask

    initial begin
        logic       seen;
        logic [3:0] acc;
        passed = 0;
        total  = 0;

        // ch0 rising, ch1 both (3-cycle glitch), ch2/ch3 idle
        tbl[0] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[2] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tbl[3] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        tbl[6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
        tbl[7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
        tbl[8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};

        sync_reset   = 1'b1;
        signal_input = 4'b0000;
        mode         = 8'b11_10_11_01;
        event_clear  = 4'b0000;
        tick();
        tick();
        check_all_zero("reset");

        sync_reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            signal_input = tbl[i].sig;
            tick();
            check($sformatf("tbl%0d_level", i),   32'(signal_level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_pulse", i),   32'(edge_pulse),   32'(tbl[i].pulse));
            check($sformatf("tbl%0d_pending", i), 32'(edge_pending), 32'(tbl[i].pend));
            check($sformatf("tbl%0d_missed", i),  32'(edge_missed),  32'h0);
            check($sformatf("tbl%0d_any", i),     32'(any_pending),  32'(|tbl[i].pend));
        end

        // ch1 glitch must not have left a partial count: a clean rise takes full latency
        wait_edge(1, 1'b1, 1'b1, "ch1_rise_after_glitch");
        event_clear[1] = 1'b1;
        tick();
        event_clear[1] = 1'b0;
        wait_edge(1, 1'b0, 1'b1, "ch1_fall");
        event_clear[1] = 1'b1;
        tick();
        event_clear[1] = 1'b0;

        // ch2 falling-only: rise is silent, fall pulses
        wait_edge(2, 1'b1, 1'b0, "ch2_rise");
        seen = 1'b0;
        for (int k = 0; k < 13; k++) begin
            tick();
            seen = seen | edge_pulse[2] | edge_pending[2];
        end
        check("ch2_quiet_while_high", 32'(seen), 32'h0);
        wait_edge(2, 1'b0, 1'b1, "ch2_fall");
        check("ch2_pending_after_fall", 32'(edge_pending[2]), 32'h1);
        check("ch2_missed_after_fall",  32'(edge_missed[2]),  32'h0);

        // ch0 both-edge overrun then clear
        event_clear[0] = 1'b1;
        tick();
        event_clear[0] = 1'b0;
        check("ch0_cleared", 32'(edge_pending[0]), 32'h0);
        mode[1:0] = 2'b11;
        wait_edge(0, 1'b0, 1'b1, "ch0_fall");
        check("ch0_pending_first",  32'(edge_pending[0]), 32'h1);
        check("ch0_missed_first",   32'(edge_missed[0]),  32'h0);
        wait_edge(0, 1'b1, 1'b1, "ch0_rise");
        check("ch0_pending_second", 32'(edge_pending[0]), 32'h1);
        check("ch0_missed_second",  32'(edge_missed[0]),  32'h1);
        event_clear[0] = 1'b1;
        tick();
        event_clear[0] = 1'b0;
        check("ch0_pending_clr", 32'(edge_pending[0]), 32'h0);
        check("ch0_missed_clr",  32'(edge_missed[0]),  32'h0);

        // ch3 clear coinciding with a pulse while already pending: set wins
        wait_edge(3, 1'b1, 1'b1, "ch3_rise");
        check("ch3_pending_first", 32'(edge_pending[3]), 32'h1);
        signal_input[3] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("ch3_fall_pulse", 32'(edge_pulse[3]), 32'h1);
        event_clear[3] = 1'b1;
        tick();
        event_clear[3] = 1'b0;
        check("ch3_pending_set_wins", 32'(edge_pending[3]), 32'h1);
        check("ch3_missed_set_wins",  32'(edge_missed[3]),  32'h0);
        event_clear[3] = 1'b1;
        tick();
        event_clear[3] = 1'b0;
        check("ch3_pending_clr", 32'(edge_pending[3]), 32'h0);

        // Reset mid-debounce on ch1 with ch0 and ch1 held high
        signal_input[1] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        sync_reset = 1'b1;
        tick();
        check_all_zero("mid_reset_a");
        tick();
        check_all_zero("mid_reset_b");
        sync_reset = 1'b0;
        acc = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            acc = acc | edge_pulse | signal_level;
        end
        check("post_reset_early", 32'(acc), 32'h0);
        tick();
        check("post_reset_pulse", 32'(edge_pulse),   32'h3);
        check("post_reset_level", 32'(signal_level), 32'h3);
        tick();
        check("post_reset_pulse_off", 32'(edge_pulse),   32'h0);
        check("post_reset_pending",   32'(edge_pending), 32'h3);
        check("post_reset_any",       32'(any_pending),  32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
